// File: rtl/ecc_field_pkg.sv
// Shared constants and FSM encoding for the GF(2^255-19) limb-serial datapath.
package ecc_field_pkg;

  localparam int unsigned W     = 64;
  localparam int unsigned N     = 256;
  localparam int unsigned LIMBS = N / W;
  localparam int unsigned CNT_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;

  // p = 2^255 - 19
  localparam logic [N-1:0] P25519 = {1'b0, {(N-6){1'b1}}, 5'b01101};

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/limb_addsub.sv
// One W-bit add/subtract slice; in subtract mode cin/cout are borrow-in/borrow-out.
module limb_addsub #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] r,
  output logic         cout
);

  logic [W:0]   sum;
  logic [W-1:0] y_eff;
  logic         c_eff;

  // x - y - b is computed as x + ~y + ~b; a carry-out of 1 means no borrow.
  always_comb begin
    y_eff = sub ? ~y : y;
    c_eff = sub ? ~cin : cin;
    sum   = {1'b0, x} + {1'b0, y_eff} + (W+1)'(c_eff);
    r     = sum[W-1:0];
    cout  = sub ? ~sum[W] : sum[W];
  end

endmodule

// File: rtl/simple_modular_subtractor.sv
// Constant-time limb-serial (a - b) mod p: subtract pass, then add p-or-0 correction pass.
module simple_modular_subtractor
  import ecc_field_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] out,
  output logic         busy,
  output logic         done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMBS - 1);

  state_t           state;
  logic [N-1:0]     a_sr;
  logic [N-1:0]     b_sr;
  logic [N-1:0]     p_sr;
  logic [N-1:0]     diff_sr;
  logic             flag;
  logic             fix;
  logic [CNT_W-1:0] cnt;

  logic [W-1:0]     x_c;
  logic [W-1:0]     y_c;
  logic [W-1:0]     r_c;
  logic             sub_c;
  logic             cout_c;

  // Shared slice operands: borrow chain in SUB, carry chain in FIX.
  always_comb begin
    sub_c = (state == SUB);
    x_c   = sub_c ? a_sr[W-1:0] : diff_sr[W-1:0];
    y_c   = sub_c ? b_sr[W-1:0] : (fix ? p_sr[W-1:0] : '0);
  end

  limb_addsub #(.W(W)) u_limb (
    .x    (x_c),
    .y    (y_c),
    .cin  (flag),
    .sub  (sub_c),
    .r    (r_c),
    .cout (cout_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      p_sr    <= '0;
      diff_sr <= '0;
      flag    <= 1'b0;
      fix     <= 1'b0;
      cnt     <= '0;
      out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            p_sr  <= P25519;
            flag  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SUB;
          end
        end
        SUB: begin
          diff_sr <= {r_c, diff_sr[N-1:W]};
          a_sr    <= a_sr >> W;
          b_sr    <= b_sr >> W;
          flag    <= cout_c;
          if (cnt == LAST) begin
            fix   <= cout_c;
            flag  <= 1'b0;
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          diff_sr <= {r_c, diff_sr[N-1:W]};
          p_sr    <= p_sr >> W;
          flag    <= cout_c;
          if (cnt == LAST) begin
            // Final carry-out dropped: result is taken mod 2^N.
            out   <= {r_c, diff_sr[N-1:W]};
            done  <= 1'b1;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_modular_subtractor.sv
// Directed and random checks of the limb-serial modular subtractor.
module tb_simple_modular_subtractor;

  localparam logic [255:0] P     = {1'b0, {250{1'b1}}, 5'b01101};
  localparam logic [255:0] TWO64 = 256'h1_0000_0000_0000_0000;
  localparam int           LAT   = 9;
  localparam int           TMO   = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] a = '0;
  logic [255:0] b = '0;
  logic [255:0] out;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  simple_modular_subtractor dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  // Launch one operation and wait (bounded) for done; lat is the done cycle index.
  task automatic do_op(input logic [255:0] av, input logic [255:0] bv,
                       output logic [255:0] res, output int lat);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    res = out;
  endtask

  function automatic logic [255:0] ref_sub(input logic [255:0] x, input logic [255:0] y);
    if (x >= y) return x - y;
    return x + P - y;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: out=%h busy=%b done=%b, required out=0 busy=0 done=0", out, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_timing();
    logic ok_busy, ok_done;
    @(negedge clk);
    a = 256'd10; b = 256'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok_busy = 1'b1; ok_done = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (busy !== (cyc <= LAT)) ok_busy = 1'b0;
      if (done !== (cyc == LAT)) ok_done = 1'b0;
      if (cyc == LAT) begin
        n_cmp++;
        if (out !== 256'd7) begin
          n_err++;
          $display("FAIL timing_out: got %h, required 7", out);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok_busy) begin
      n_err++;
      $display("FAIL busy_window: busy not high exactly over cycles 1..%0d (got 0, required 1)", LAT);
    end
    n_cmp++;
    if (!ok_done) begin
      n_err++;
      $display("FAIL done_pulse: done not a single pulse at cycle %0d (got 0, required 1)", LAT);
    end
  endtask

  task automatic test_vectors();
    logic [255:0] va [7];
    logic [255:0] vb [7];
    logic [255:0] ve [7];
    logic [255:0] res;
    int lat;
    va[0] = 256'd10;  vb[0] = 256'd3;  ve[0] = 256'd7;
    va[1] = 256'd3;   vb[1] = 256'd10; ve[1] = {1'b0, {250{1'b1}}, 5'b00110};
    va[2] = 256'd0;   vb[2] = 256'd1;  ve[2] = {1'b0, {250{1'b1}}, 5'b01100};
    va[3] = TWO64;    vb[3] = 256'd1;  ve[3] = {192'd0, 64'hffff_ffff_ffff_ffff};
    va[4] = P - 1;    vb[4] = P - 1;   ve[4] = 256'd0;
    va[5] = P - 1;    vb[5] = 256'd0;  ve[5] = {1'b0, {250{1'b1}}, 5'b01100};
    va[6] = 256'd0;   vb[6] = P - 1;   ve[6] = 256'd1;
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], res, lat);
      n_cmp++;
      if (lat !== LAT) begin
        n_err++;
        $display("FAIL vec%0d_latency: got %0d, required %0d", i, lat, LAT);
      end
      n_cmp++;
      if (res !== ve[i]) begin
        n_err++;
        $display("FAIL vec%0d_out: got %h, required %h", i, res, ve[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [255:0] res;
    int lat;
    bit extra_done;
    @(negedge clk);
    a = 256'd10; b = 256'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < LAT; cyc++) begin
      if (cyc == 3) begin
        a = 256'd5; b = 256'd100; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    // cycle 9 (DONE): pulse start again, must not be accepted
    a = 256'd1; b = 256'd2; start = 1'b1;
    n_cmp++;
    if (done !== 1'b1 || out !== 256'd7) begin
      n_err++;
      $display("FAIL ignore_first_result: done=%b out=%h, required done=1 out=7", done, out);
    end
    @(negedge clk);
    start = 1'b0;
    extra_done = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (done === 1'b1 || busy === 1'b1) extra_done = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (extra_done || out !== 256'd7) begin
      n_err++;
      $display("FAIL ignore_no_accept: activity=%b out=%h, required activity=0 out=7", extra_done, out);
    end
    do_op(256'd100, 256'd58, res, lat);
    n_cmp++;
    if (res !== 256'd42 || lat !== LAT) begin
      n_err++;
      $display("FAIL ignore_next_op: out=%h lat=%0d, required out=2a lat=%0d", res, lat, LAT);
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] res;
    int lat;
    bit saw_done;
    @(negedge clk);
    a = 256'd3; b = 256'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: out=%h busy=%b done=%b, required 0/0/0", out, busy, done);
    end
    saw_done = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (saw_done) begin
      n_err++;
      $display("FAIL reset_mid_no_done: done pulsed=1, required 0");
    end
    do_op(256'd0, 256'd1, res, lat);
    n_cmp++;
    if (res !== P - 1 || lat !== LAT) begin
      n_err++;
      $display("FAIL reset_mid_recover: out=%h lat=%0d, required %h lat=%0d", res, lat, P - 1, LAT);
    end
  endtask

  task automatic test_random();
    logic [255:0] x, y, res, exp;
    int lat;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 8; k++) begin
        x[k*32 +: 32] = $urandom;
        y[k*32 +: 32] = $urandom;
      end
      x[255] = 1'b0;
      y[255] = 1'b0;
      if (x >= P) x = x - P;
      if (y >= P) y = y - P;
      if (i % 4 == 0) y = x + 256'd0;
      exp = ref_sub(x, y);
      do_op(x, y, res, lat);
      n_cmp++;
      if (res !== exp || lat !== LAT) begin
        n_err++;
        $display("FAIL random%0d: a=%h b=%h out=%h lat=%0d, required %h lat=%0d", i, x, y, res, lat, exp, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_vectors();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
